// File: rtl/if_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared definitions for the instruction-fetch responder:
//   - InstAddrBus / InstBus : address and instruction word widths
//   - IcacheIndexW          : default log2 of instruction-cache lines
//   - if_state_e            : fetch FSM encodings (IfIdle, IfFetch)
//   - byte_addr()           : byte address of byte idx within a fetch word
// Optional feature macro used by the users of this package: ICACHE_EN.
// ---------------------------------------------------------------------------
package if_fetch_unit_pkg;

  localparam int InstAddrBus  = 32;
  localparam int InstBus      = 32;
  localparam int IcacheIndexW = 4;

  typedef enum logic {
    IfIdle  = 1'b0,
    IfFetch = 1'b1
  } if_state_e;

  // Byte address arithmetic wraps modulo 2^32.
  function automatic logic [InstAddrBus-1:0] byte_addr(
    input logic [InstAddrBus-1:0] base,
    input logic [1:0]             idx
  );
    return base + {{(InstAddrBus-2){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/if_fetch_unit_icache_dm.sv
// ---------------------------------------------------------------------------
// icache_dm
// Direct-mapped instruction cache, one 32-bit word per line. Only compiled
// when ICACHE_EN is defined.
// Ports:
//   clk, rst            clock, asynchronous active-high reset (valid bits)
//   rd_index, rd_tag    lookup address split into index and tag
//   hit, rd_word        combinational lookup result
//   fill                write enable for one line
//   fill_index/tag/word line contents written on the rising edge
// Valid bits are cleared only by reset; there is no invalidation port.
// ---------------------------------------------------------------------------
`ifdef ICACHE_EN
module icache_dm
  import if_fetch_unit_pkg::*;
#(
  parameter int INDEX_W = IcacheIndexW,
  parameter int TAG_W   = InstAddrBus - IcacheIndexW - 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [TAG_W-1:0]   rd_tag,
  output logic               hit,
  output logic [InstBus-1:0] rd_word,
  input  logic               fill,
  input  logic [INDEX_W-1:0] fill_index,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [InstBus-1:0] fill_word
);

  localparam int Lines = 1 << INDEX_W;

  logic [Lines-1:0]   line_valid;
  logic [TAG_W-1:0]   line_tag  [Lines];
  logic [InstBus-1:0] line_word [Lines];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_valid <= '0;
    end else if (fill) begin
      line_valid[fill_index] <= 1'b1;
    end
  end

  // Tag and data arrays need no reset: they are qualified by line_valid.
  always_ff @(posedge clk) begin
    if (fill) begin
      line_tag[fill_index]  <= fill_tag;
      line_word[fill_index] <= fill_word;
    end
  end

  assign hit     = line_valid[rd_index] && (line_tag[rd_index] == rd_tag);
  assign rd_word = line_word[rd_index];

endmodule
`endif

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch responder between the PC register and a byte-wide
// memory port. Assembles a little-endian 32-bit word from four byte reads,
// keeps the last completed word in a one-word buffer and stalls the pipeline
// until the word for the current pc is available.
// Optional feature: define ICACHE_EN to add a direct-mapped cache of
// 2^ICACHE_INDEX_W one-word lines (icache_dm), filled on every completed fetch.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   ce, pc       fetch enable and word-aligned fetch address
//   mem_rdata    byte returned by memory
//   mem_rvalid   completes the outstanding byte request
//   mem_rd_req   byte read request, held until mem_rvalid
//   mem_addr     byte address, stable while mem_rd_req is high
//   inst         instruction word for pc (0 when not valid)
//   inst_valid   inst corresponds to the current pc
//   stall_req    stall request to the pipeline controller
// ---------------------------------------------------------------------------
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int ICACHE_INDEX_W = IcacheIndexW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic [InstAddrBus-1:0] pc,
  input  logic [7:0]             mem_rdata,
  input  logic                   mem_rvalid,
  output logic                   mem_rd_req,
  output logic [InstAddrBus-1:0] mem_addr,
  output logic [InstBus-1:0]     inst,
  output logic                   inst_valid,
  output logic                   stall_req
);

  localparam int TagW = InstAddrBus - ICACHE_INDEX_W - 2;

  if_state_e              state;
  logic [InstAddrBus-1:0] fetch_base;
  logic [1:0]             cnt;
  logic [23:0]            asm_word;
  logic                   abort_q;
  logic [InstBus-1:0]     buf_word;
  logic [InstAddrBus-1:0] buf_pc;
  logic                   buf_valid;

  logic                   buf_hit;
  logic                   cache_hit;
  logic [InstBus-1:0]     cache_word;
  logic                   word_ready;
  logic                   aborting;
  logic                   fill;
  logic [InstBus-1:0]     fill_word;

  assign buf_hit    = buf_valid && (buf_pc == pc);
  assign word_ready = ce && (buf_hit || cache_hit);

  // Once a redirect or ce drop is seen, the fetch stays aborted even if pc
  // returns to fetch_base before the outstanding byte arrives.
  assign aborting   = abort_q || !ce || (pc != fetch_base);

  // Byte 3 comes straight from the memory port, so the word is complete
  // in the cycle its last byte is accepted.
  assign fill       = (state == IfFetch) && mem_rvalid && !aborting && (cnt == 2'd3);
  assign fill_word  = {mem_rdata, asm_word};

  assign inst_valid = word_ready;
  assign inst       = !word_ready ? '0 : (cache_hit ? cache_word : buf_word);
  assign stall_req  = ce && !word_ready;

`ifdef ICACHE_EN
  logic cache_lookup_hit;

  icache_dm #(
    .INDEX_W (ICACHE_INDEX_W),
    .TAG_W   (TagW)
  ) u_icache (
    .clk        (clk),
    .rst        (rst),
    .rd_index   (pc[ICACHE_INDEX_W+1:2]),
    .rd_tag     (pc[InstAddrBus-1:ICACHE_INDEX_W+2]),
    .hit        (cache_lookup_hit),
    .rd_word    (cache_word),
    .fill       (fill),
    .fill_index (fetch_base[ICACHE_INDEX_W+1:2]),
    .fill_tag   (fetch_base[InstAddrBus-1:ICACHE_INDEX_W+2]),
    .fill_word  (fill_word)
  );

  assign cache_hit = cache_lookup_hit;
`else
  // No cache storage: these bits only feed the cache in the other build.
  logic [ICACHE_INDEX_W:0] cache_unused;

  assign cache_unused = {fill, pc[ICACHE_INDEX_W+1:2]};
  assign cache_hit    = 1'b0;
  assign cache_word   = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IfIdle;
      mem_rd_req <= 1'b0;
      mem_addr   <= '0;
      fetch_base <= '0;
      cnt        <= 2'd0;
      asm_word   <= '0;
      abort_q    <= 1'b0;
      buf_word   <= '0;
      buf_pc     <= '0;
      buf_valid  <= 1'b0;
    end else begin
      case (state)
        IfIdle: begin
          if (ce && !word_ready) begin
            fetch_base <= pc;
            cnt        <= 2'd0;
            abort_q    <= 1'b0;
            mem_rd_req <= 1'b1;
            mem_addr   <= pc;
            state      <= IfFetch;
          end
        end

        IfFetch: begin
          if (mem_rvalid) begin
            if (aborting) begin
              // Outstanding byte is consumed and everything collected dropped.
              mem_rd_req <= 1'b0;
              abort_q    <= 1'b0;
              cnt        <= 2'd0;
              state      <= IfIdle;
            end else if (cnt == 2'd3) begin
              buf_word   <= fill_word;
              buf_pc     <= fetch_base;
              buf_valid  <= 1'b1;
              mem_rd_req <= 1'b0;
              cnt        <= 2'd0;
              state      <= IfIdle;
            end else begin
              case (cnt)
                2'd0:    asm_word[7:0]   <= mem_rdata;
                2'd1:    asm_word[15:8]  <= mem_rdata;
                default: asm_word[23:16] <= mem_rdata;
              endcase
              cnt      <= cnt + 2'd1;
              mem_addr <= byte_addr(fetch_base, cnt + 2'd1);
            end
          end else begin
            abort_q <= aborting;
          end
        end

        default: begin
          mem_rd_req <= 1'b0;
          state      <= IfIdle;
        end
      endcase
    end
  end

endmodule
